// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) helpers and FSM state type for the AES inverse MixColumns engine.
// Constant multiplies are built purely from chained xtime steps.
package aes_gf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] GF_POLY = 8'h1B;

  // Inverse MixColumns row coefficients, in rotation order Ai, Ai+1, Ai+2, Ai+3.
  localparam logic [3:0] INV_K0 = 4'hE;
  localparam logic [3:0] INV_K1 = 4'hB;
  localparam logic [3:0] INV_K2 = 4'hD;
  localparam logic [3:0] INV_K3 = 4'h9;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    logic [7:0] shifted;
    shifted = {a[6:0], 1'b0};
    return a[7] ? (shifted ^ GF_POLY) : shifted;
  endfunction

  // Multiply by a 4-bit constant: accumulate a, 2a, 4a, 8a selected by the bits of k.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] pow;
    logic [7:0] acc;
    pow = a;
    acc = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ pow;
      pow = xtime(pow);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_byte.sv
// One output byte of inverse MixColumns; inputs arrive already rotated so that
// a0 is the byte in the same lane as the result.
module inv_mix_byte
  import aes_gf_pkg::*;
(
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] a3,
  output logic [7:0] b
);

  logic [7:0] term [4];

  assign term[0] = gf_mul(a0, INV_K0);
  assign term[1] = gf_mul(a1, INV_K1);
  assign term[2] = gf_mul(a2, INV_K2);
  assign term[3] = gf_mul(a3, INV_K3);

  assign b = term[0] ^ term[1] ^ term[2] ^ term[3];

endmodule

// File: rtl/inv_mix_column_seq.sv
// Sequential AES inverse MixColumns: one column in, one byte per cycle through a
// single shared byte datapath, result held in DONE until the downstream takes it.
module inv_mix_column_seq
  import aes_gf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  state_t      state_reg;
  state_t      state_next;
  logic [1:0]  cnt_reg;
  logic [31:0] col_reg;
  logic [7:0]  lane_reg [4];
  logic [7:0]  col_byte [4];
  logic [7:0]  rot_byte [4];
  logic [7:0]  byte_out;
  logic        accept;

  // Byte 0 is the most significant lane; rotation by the counter lines up Ai..Ai+3.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
    assign col_byte[gi] = col_reg[31 - 8*gi -: 8];
    assign rot_byte[gi] = col_byte[cnt_reg + 2'(gi)];
  end

  inv_mix_byte u_byte (
    .a0 (rot_byte[0]),
    .a1 (rot_byte[1]),
    .a2 (rot_byte[2]),
    .a3 (rot_byte[3]),
    .b  (byte_out)
  );

  // in_ready is forced low during reset so nothing is accepted on a reset edge.
  assign in_ready  = rst_n && ((state_reg == ST_IDLE) ||
                               (state_reg == ST_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign out_data  = {lane_reg[0], lane_reg[1], lane_reg[2], lane_reg[3]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid) state_next = ST_CALC;
      ST_CALC: if (cnt_reg == 2'd3) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = in_valid ? ST_CALC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 2'd0;
      col_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        col_reg <= in_data;
        cnt_reg <= 2'd0;
      end else if (state_reg == ST_CALC) begin
        cnt_reg <= cnt_reg + 2'd1;
      end
    end
  end

  // Each lane loads only on its own CALC cycle, so lanes stay frozen in DONE.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lane_reg[gi] <= 8'h00;
      end else if (state_reg == ST_CALC && cnt_reg == 2'(gi)) begin
        lane_reg[gi] <= byte_out;
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Directed and randomized checks of inv_mix_column_seq against hand-computed
// vectors and a forward MixColumns reference model.
module tb_inv_mix_column_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam int N_RAND   = 10000;
  localparam int MAX_CYC  = 90000;

  inv_mix_column_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m2(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [31:0] fwd_mix(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) a[i] = c[31 - 8*i -: 8];
    for (int i = 0; i < 4; i++)
      b[i] = m2(a[i]) ^ m2(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after the accept edge; waits the remaining CALC edges, then the DONE edge.
  task automatic wait_result(input int n_low, input logic [31:0] exp, input string tag);
    int hi;
    hi = 0;
    repeat (n_low) begin
      @(posedge clk); #1;
      if (out_valid) hi++;
    end
    check({tag, "_early_valid"}, 32'(hi), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp);
  endtask

  task automatic accept_col(input logic [31:0] d);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int bad;
    int hi;
    int sent;
    int recv;
    int cyc;
    logic [31:0] held;
    logic [31:0] exp;
    logic [31:0] q [$];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic vector with exact latency
    accept_col(32'h8E4DA1BC);
    check("calc_in_ready", {31'd0, in_ready}, 32'd0);
    wait_result(3, 32'hDB135345, "v1");

    // Backpressure for 10 cycles in DONE
    held = out_data;
    bad  = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check("stall_stable", 32'(bad), 32'd0);

    // Simultaneous output and input handshake
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h8E4DA1BC;
    #1;
    check("dual_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("dual_to_calc", {31'd0, out_valid}, 32'd0);
    wait_result(3, 32'hDB135345, "dual");
    drain("dual");

    // in_valid pulse during CALC is ignored
    accept_col(32'h9FDC589D);
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    #1;
    check("calc_ignore_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(1, 32'hF20A225C, "v2");
    drain("v2");

    accept_col(32'h01010101);
    wait_result(3, 32'h01010101, "v3");
    drain("v3");

    accept_col(32'hC6C6C6C6);
    wait_result(3, 32'hC6C6C6C6, "v4");
    drain("v4");

    // Reset in the middle of CALC (counter == 2)
    accept_col(32'h8E4DA1BC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rel_ready", {31'd0, in_ready}, 32'd1);
    hi = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) hi++;
    end
    check("midrst_no_result", 32'(hi), 32'd0);
    accept_col(32'h9FDC589D);
    wait_result(3, 32'hF20A225C, "post_rst");
    drain("post_rst");

    // Random columns with random stalls, checked through the forward model
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < N_RAND && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < N_RAND) && ($urandom_range(7) != 0);
      in_data   = $urandom();
      out_ready = ($urandom_range(7) != 0);
      #1;
      if (out_valid && out_ready) begin
        exp = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
        check("rand_roundtrip", fwd_mix(out_data), exp);
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_count", 32'(recv), 32'(N_RAND));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
